// File: rtl/tetris_line_clear.sv
// Line-clear engine: snapshots the playfield, removes full rows bottom-up
// one row per clock, and keeps a saturating running line total.
module tetris_line_clear #(
  parameter int ROWS    = 22,
  parameter int COLS    = 10,
  parameter int CW      = 3,
  parameter int TOTAL_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         total_clr,
  input  logic [ROWS*COLS*CW-1:0]      grid_i,
  output logic [ROWS*COLS*CW-1:0]      grid_o,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(ROWS+1)-1:0]    lines_cleared,
  output logic [TOTAL_W-1:0]           lines_total
);

  localparam int RW  = COLS * CW;
  localparam int NW  = $clog2(ROWS + 1);
  localparam int RPW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW  = ((TOTAL_W > NW) ? TOTAL_W : NW) + 1;
  localparam logic [SW-1:0] TMAX =
    {{(SW-TOTAL_W){1'b0}}, {TOTAL_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    FIN
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ROWS-1:0][RW-1:0] grid_q;
  logic [RPW-1:0]          r_q;
  logic [RW-1:0]           cur_row;
  logic                    row_full;
  logic [SW-1:0]           sum;

  assign grid_o  = grid_q;
  assign busy    = (state_q == LOAD) || (state_q == SCAN);
  assign done    = (state_q == FIN);
  assign cur_row = grid_q[r_q];
  assign sum     = SW'(lines_total) + SW'(lines_cleared);

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (cur_row[c*CW +: CW] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = SCAN;
      SCAN: if (!row_full && r_q == '0) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A full row pulls every row above it down by one; the pointer stays
  // put so the row that dropped into place gets checked next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_q        <= '0;
      r_q           <= '0;
      lines_cleared <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          grid_q        <= grid_i;
          r_q           <= RPW'(ROWS - 1);
          lines_cleared <= '0;
        end
        SCAN: begin
          if (row_full) begin
            for (int k = 1; k < ROWS; k++) begin
              if (k <= int'(r_q)) grid_q[k] <= grid_q[k-1];
            end
            grid_q[0]     <= '0;
            lines_cleared <= lines_cleared + NW'(1);
          end else if (r_q != '0) begin
            r_q <= r_q - RPW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lines_total <= '0;
    end else if (total_clr) begin
      lines_total <= '0;
    end else if (state_q == FIN) begin
      if (sum > TMAX) lines_total <= '1;
      else            lines_total <= sum[TOTAL_W-1:0];
    end
  end

endmodule

// File: tb/tb_tetris_line_clear.sv
// Bench for tetris_line_clear: per-cycle model compare on a 16-bit-total
// instance plus directed checks, and a 4-bit-total instance for saturation.
module tb_tetris_line_clear;

  localparam int ROWS = 22;
  localparam int COLS = 10;
  localparam int CW   = 3;
  localparam int GW   = ROWS * COLS * CW;
  localparam int NW   = $clog2(ROWS + 1);

  typedef logic [GW-1:0] grid_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_v [2];
  logic          clr_v   [2];
  grid_t         grid_v  [2];
  grid_t         go      [2];
  logic          busy_w  [2];
  logic          done_w  [2];
  logic [NW-1:0] lc_w    [2];
  logic [15:0]   tot0;
  logic [3:0]    tot1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tetris_line_clear #(
    .ROWS(ROWS), .COLS(COLS), .CW(CW), .TOTAL_W(16)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .start(start_v[0]), .total_clr(clr_v[0]),
    .grid_i(grid_v[0]), .grid_o(go[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .lines_cleared(lc_w[0]), .lines_total(tot0)
  );

  tetris_line_clear #(
    .ROWS(ROWS), .COLS(COLS), .CW(CW), .TOTAL_W(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start(start_v[1]), .total_clr(clr_v[1]),
    .grid_i(grid_v[1]), .grid_o(go[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .lines_cleared(lc_w[1]), .lines_total(tot1)
  );

  task automatic chk(input string nm, input grid_t act, input grid_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic grid_t set_cell(input grid_t g, input int r,
                                     input int c, input logic [CW-1:0] v);
    g[(r*COLS+c)*CW +: CW] = v;
    return g;
  endfunction

  function automatic grid_t fill_row(input grid_t g, input int r,
                                     input logic [CW-1:0] v);
    for (int c = 0; c < COLS; c++) g = set_cell(g, r, c, v);
    return g;
  endfunction

  // Result of a pass: surviving rows stacked at the bottom in order.
  function automatic grid_t compact(input grid_t g, output int n);
    grid_t res;
    int    k;
    bit    full;
    res = '0;
    k   = ROWS - 1;
    n   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (g[(r*COLS+c)*CW +: CW] == '0) full = 1'b0;
      if (full) begin
        n++;
      end else begin
        res[k*COLS*CW +: COLS*CW] = g[r*COLS*CW +: COLS*CW];
        k--;
      end
    end
    return res;
  endfunction

  // Model phases: 0 idle, 1 loading, 2 scanning, 3 result cycle.
  int      m_phase = 0;
  int      m_cnt   = 0;
  int      m_n     = 0;
  longint  m_total = 0;
  grid_t   m_grid  = '0;
  bit      m_on    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_n     = 0;
      m_total = 0;
      m_grid  = '0;
    end else begin
      case (m_phase)
        0: if (start_v[0]) m_phase = 1;
        1: begin
          m_grid  = compact(grid_v[0], m_n);
          m_cnt   = ROWS + m_n;
          m_phase = 2;
        end
        2: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 3;
        end
        default: begin
          if (!clr_v[0]) begin
            m_total = m_total + m_n;
            if (m_total > 65535) m_total = 65535;
          end
          m_phase = 0;
        end
      endcase
      if (clr_v[0]) m_total = 0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_busy", grid_t'(busy_w[0]),
          grid_t'(m_phase == 1 || m_phase == 2));
      chk("m_done", grid_t'(done_w[0]), grid_t'(m_phase == 3));
      chk("m_total", grid_t'(tot0), grid_t'(m_total[15:0]));
      if (m_phase == 0 || m_phase == 3) begin
        chk("m_grid", go[0], m_grid);
        chk("m_lc", grid_t'(lc_w[0]), grid_t'(m_n));
      end
    end
  end

  grid_t         r_grid;
  logic [NW-1:0] r_lc;

  task automatic run_pass(input int d, input grid_t g, input bit clr_fin,
                          input bit poke, output int cyc);
    grid_v[d]  = g;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    cyc = 1;
    while (done_w[d] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start_v[d] = poke && cyc == 5;
      if (poke && cyc == 5) grid_v[d] = '0;
    end
    start_v[d] = 1'b0;
    if (cyc >= 200) chk("done_timeout", grid_t'(cyc), grid_t'(0));
    r_grid    = go[d];
    r_lc      = lc_w[d];
    clr_v[d]  = clr_fin;
    @(negedge clk);
    clr_v[d]  = 1'b0;
  endtask

  task automatic pulse_clr(input int d);
    clr_v[d] = 1'b1;
    @(negedge clk);
    clr_v[d] = 1'b0;
  endtask

  initial begin
    grid_t g;
    grid_t e;
    int    cyc;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      clr_v[i]   = 1'b0;
      grid_v[i]  = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", grid_t'(busy_w[0]), grid_t'(0));
    chk("rst_grid", go[0], '0);
    chk("rst_total", grid_t'(tot0), grid_t'(0));
    rst_n = 1'b1;
    m_on  = 1'b1;
    @(negedge clk);

    // 1: empty grid
    run_pass(0, '0, 1'b0, 1'b0, cyc);
    chk("t1_latency", grid_t'(cyc), grid_t'(24));
    chk("t1_lc", grid_t'(r_lc), grid_t'(0));
    chk("t1_grid", r_grid, '0);

    // 2: single full bottom row
    g = fill_row('0, 21, 3'b100);
    g = set_cell(g, 20, 0, 3'b010);
    e = set_cell('0, 21, 0, 3'b010);
    run_pass(0, g, 1'b0, 1'b0, cyc);
    chk("t2_latency", grid_t'(cyc), grid_t'(25));
    chk("t2_lc", grid_t'(r_lc), grid_t'(1));
    chk("t2_grid", r_grid, e);

    // 3: four full rows around a partial one
    pulse_clr(0);
    g = '0;
    g = fill_row(g, 21, 3'b101);
    g = fill_row(g, 20, 3'b011);
    g = fill_row(g, 18, 3'b110);
    g = fill_row(g, 17, 3'b001);
    g = set_cell(g, 19, 4, 3'b001);
    e = set_cell('0, 21, 4, 3'b001);
    run_pass(0, g, 1'b0, 1'b0, cyc);
    chk("t3_latency", grid_t'(cyc), grid_t'(28));
    chk("t3_lc", grid_t'(r_lc), grid_t'(4));
    chk("t3_grid", r_grid, e);
    chk("t3_total", grid_t'(tot0), grid_t'(4));

    // 4: all rows full, twice; second pass pokes start and grid_i mid-scan
    pulse_clr(0);
    g = '0;
    for (int r = 0; r < ROWS; r++) g = fill_row(g, r, 3'b111);
    for (int p = 0; p < 2; p++) begin
      run_pass(0, g, 1'b0, p == 1, cyc);
      chk("t4_latency", grid_t'(cyc), grid_t'(46));
      chk("t4_lc", grid_t'(r_lc), grid_t'(22));
      chk("t4_grid", r_grid, '0);
    end
    chk("t4_total", grid_t'(tot0), grid_t'(44));

    // 5: asynchronous reset mid-scan
    grid_v[0]  = g;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", grid_t'(busy_w[0]), grid_t'(0));
    chk("t5_done", grid_t'(done_w[0]), grid_t'(0));
    chk("t5_grid", go[0], '0);
    chk("t5_lc", grid_t'(lc_w[0]), grid_t'(0));
    chk("t5_total", grid_t'(tot0), grid_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    g = fill_row('0, 21, 3'b100);
    g = set_cell(g, 20, 0, 3'b010);
    e = set_cell('0, 21, 0, 3'b010);
    run_pass(0, g, 1'b0, 1'b0, cyc);
    chk("t5_latency", grid_t'(cyc), grid_t'(25));
    chk("t5_regrid", r_grid, e);
    chk("t5_retotal", grid_t'(tot0), grid_t'(1));

    // 6: 4-bit total saturation and clear in the result cycle
    g = '0;
    for (int r = 8; r < ROWS; r++) g = fill_row(g, r, 3'b010);
    run_pass(1, g, 1'b0, 1'b0, cyc);
    chk("t6_lc14", grid_t'(r_lc), grid_t'(14));
    chk("t6_total14", grid_t'(tot1), grid_t'(14));
    g = '0;
    for (int r = 19; r < ROWS; r++) g = fill_row(g, r, 3'b011);
    run_pass(1, g, 1'b0, 1'b0, cyc);
    chk("t6_latency", grid_t'(cyc), grid_t'(27));
    chk("t6_sat", grid_t'(tot1), grid_t'(15));
    run_pass(1, g, 1'b1, 1'b0, cyc);
    chk("t6_clr_fin", grid_t'(tot1), grid_t'(0));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
